pipe_ctrl: RTL and testbench

//  Pipeline hazard controller; drives stall[5:0] to every pipeline register (pc_reg..mem_wb)
//  and the flush/new_pc pair to pc_reg and all stage registers.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants for the pipeline hazard controller.
//   - Stop/NoStop levels for the per-stage stall bits
//   - STALL_NONE/STALL_ID/STALL_EX stall vector encodings
//   - 2-bit FSM state codes (idle/busy/done/flush)
//   - RST_ENABLE: reset assertion level (active-low for this block)
package pipe_ctrl_pkg;

    localparam logic RST_ENABLE = 1'b0;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Bit order: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        PIPE_CTRL_IDLE  = 2'd0,
        PIPE_CTRL_BUSY  = 2'd1,
        PIPE_CTRL_DONE  = 2'd2,
        PIPE_CTRL_FLUSH = 2'd3
    } pipe_ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller.
//   Merges ID/EX stall requests into a 6-bit stall vector, sequences
//   multi-cycle EX operations with a down-counter and issues registered
//   one-cycle flushes with a redirect PC.
// Ports:
//   clk, rst (async, active-low)
//   stallreq_from_id, stallreq_from_ex : stall requests (combinational)
//   mc_start, mc_cycles, mc_abort      : multi-cycle op control
//   flush_req, flush_pc                : redirect request and target
//   stall[5:0]                         : per-stage stop, [0]PC .. [5]WB
//   flush, new_pc                      : flush pulse and redirect PC
//   mc_busy, mc_done                   : multi-cycle status / result strobe
//   stall_cycles                       : stalled-cycle counter, only when
//                                        PIPE_CTRL_PERF_EN is defined
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          CNT_W    = 6,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_from_id,
    input  logic             stallreq_from_ex,
    input  logic             mc_start,
    input  logic [CNT_W-1:0] mc_cycles,
    input  logic             mc_abort,
    input  logic             flush_req,
    input  logic [31:0]      flush_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             mc_busy,
    output logic             mc_done
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    pipe_ctrl_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic [CNT_W-1:0] mc_len;

    // A zero-length request still costs one busy cycle.
    assign mc_len = (mc_cycles == '0) ? CNT_W'(1) : mc_cycles;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q  <= PIPE_CTRL_IDLE;
            cnt_q    <= '0;
            new_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            new_pc_q <= new_pc_d;
        end
    end

    // Next state; priority flush_req > mc_abort > expiry > mc_start
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        new_pc_d = new_pc_q;
        if (flush_req) begin
            state_d  = PIPE_CTRL_FLUSH;
            cnt_d    = '0;
            new_pc_d = flush_pc;
        end else begin
            case (state_q)
                PIPE_CTRL_IDLE: begin
                    if (mc_start && !mc_abort) begin
                        state_d = PIPE_CTRL_BUSY;
                        cnt_d   = mc_len;
                    end
                end
                PIPE_CTRL_BUSY: begin
                    // mc_start here is a protocol error and is ignored
                    if (mc_abort) begin
                        state_d = PIPE_CTRL_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_d = PIPE_CTRL_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                PIPE_CTRL_DONE:  state_d = PIPE_CTRL_IDLE;
                PIPE_CTRL_FLUSH: state_d = PIPE_CTRL_IDLE;
                default:         state_d = PIPE_CTRL_IDLE;
            endcase
        end
    end

    // Outputs. The flush_req cycle itself leaves stall to the current state;
    // the redirect shows up one cycle later from the FLUSH state.
    always_comb begin
        stall   = STALL_NONE;
        flush   = 1'b0;
        mc_busy = 1'b0;
        mc_done = 1'b0;
        case (state_q)
            PIPE_CTRL_IDLE: begin
                if (stallreq_from_ex || mc_start) stall = STALL_EX;
                else if (stallreq_from_id)        stall = STALL_ID;
            end
            PIPE_CTRL_BUSY: begin
                stall   = STALL_EX;
                mc_busy = 1'b1;
            end
            PIPE_CTRL_DONE: begin
                // EX must advance to capture the result, so only live
                // requests can hold it; mc_start is not honoured here.
                mc_done = 1'b1;
                if (stallreq_from_ex)      stall = STALL_EX;
                else if (stallreq_from_id) stall = STALL_ID;
            end
            PIPE_CTRL_FLUSH: flush = 1'b1;
            default: ;
        endcase
    end

    assign new_pc = new_pc_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            perf_q <= '0;
        end else if (stall[0] == STOP && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_from_id, stallreq_from_ex;
    logic        mc_start, mc_abort, flush_req;
    logic [5:0]  mc_cycles;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush, mc_busy, mc_done;
    logic [31:0] new_pc;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    pipe_ctrl #(.CNT_W(6), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .stallreq_from_id(stallreq_from_id), .stallreq_from_ex(stallreq_from_ex),
        .mc_start(mc_start), .mc_cycles(mc_cycles), .mc_abort(mc_abort),
        .flush_req(flush_req), .flush_pc(flush_pc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .mc_busy(mc_busy), .mc_done(mc_done)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        stallreq_from_id = 0; stallreq_from_ex = 0;
        mc_start = 0; mc_cycles = 0; mc_abort = 0;
        flush_req = 0; flush_pc = 0;
    endtask

    task automatic test_reset;
        rst = 0;
        idle_inputs();
        #2;
        n_chk++; if ({stall, flush, mc_busy, mc_done} !== 9'b0) begin
            n_fail++; $display("FAIL reset_outputs got %b want 0", {stall, flush, mc_busy, mc_done}); end
        n_chk++; if (new_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_new_pc got %h want 0", new_pc); end
        tick(); tick();
        rst = 1;
        tick();
        // start an 8-cycle op, reset it while cnt==5 (cycle T+4)
        mc_start = 1; mc_cycles = 6'd8;
        tick();
        mc_start = 0; mc_cycles = 0;
        tick(); tick(); tick();
        #1;
        n_chk++; if (mc_busy !== 1'b1 || stall !== 6'b001111) begin
            n_fail++; $display("FAIL mid_busy got busy=%b stall=%b want 1 001111", mc_busy, stall); end
        rst = 0;
        #1;
        n_chk++; if ({stall, flush, mc_busy, mc_done} !== 9'b0 || new_pc !== 32'h0) begin
            n_fail++; $display("FAIL async_reset got %b pc=%h want 0", {stall, flush, mc_busy, mc_done}, new_pc); end
        tick();
        rst = 1;
        for (int k = 0; k < 12; k++) begin
            #2;
            n_chk++; if (stall !== 6'b0 || mc_done !== 1'b0 || mc_busy !== 1'b0) begin
                n_fail++; $display("FAIL post_reset cyc%0d stall=%b done=%b busy=%b want 0", k, stall, mc_done, mc_busy); end
            tick();
        end
    endtask

    task automatic test_id_ex;
        stallreq_from_id = 1; #2;
        n_chk++; if (stall !== 6'b000111) begin
            n_fail++; $display("FAIL id_only got %b want 000111", stall); end
        stallreq_from_ex = 1; #1;
        n_chk++; if (stall !== 6'b001111) begin
            n_fail++; $display("FAIL id_and_ex got %b want 001111", stall); end
        stallreq_from_id = 0; #1;
        n_chk++; if (stall !== 6'b001111) begin
            n_fail++; $display("FAIL ex_only got %b want 001111", stall); end
        stallreq_from_ex = 0; #1;
        n_chk++; if (stall !== 6'b000000) begin
            n_fail++; $display("FAIL no_req got %b want 000000", stall); end
        tick();
    endtask

    task automatic test_multicycle;
        // N=3: stall T..T+3, done at T+4
        mc_start = 1; mc_cycles = 6'd3; #2;
        n_chk++; if (stall !== 6'b001111 || mc_done !== 0) begin
            n_fail++; $display("FAIL mc3_T got stall=%b done=%b want 001111 0", stall, mc_done); end
        tick();
        mc_start = 0; mc_cycles = 0;
        for (int k = 1; k <= 3; k++) begin
            #2;
            n_chk++; if (stall !== 6'b001111 || mc_busy !== 1 || mc_done !== 0) begin
                n_fail++; $display("FAIL mc3_T+%0d got stall=%b busy=%b done=%b want 001111 1 0", k, stall, mc_busy, mc_done); end
            tick();
        end
        #2;
        n_chk++; if (stall !== 6'b0 || mc_done !== 1 || mc_busy !== 0) begin
            n_fail++; $display("FAIL mc3_T+4 got stall=%b done=%b busy=%b want 0 1 0", stall, mc_done, mc_busy); end
        tick(); #2;
        n_chk++; if (mc_done !== 0) begin
            n_fail++; $display("FAIL mc3_T+5 done got %b want 0", mc_done); end
        tick();
        // N=0 treated as 1: stall T..T+1, done at T+2; ID request ignored in BUSY
        mc_start = 1; mc_cycles = 6'd0;
        tick();
        mc_start = 0; stallreq_from_id = 1; #2;
        n_chk++; if (stall !== 6'b001111 || mc_busy !== 1) begin
            n_fail++; $display("FAIL mc0_T+1 got stall=%b busy=%b want 001111 1", stall, mc_busy); end
        tick(); #2;
        n_chk++; if (stall !== 6'b000111 || mc_done !== 1) begin
            n_fail++; $display("FAIL mc0_T+2 got stall=%b done=%b want 000111 1", stall, mc_done); end
        tick();
        stallreq_from_id = 0; #2;
        n_chk++; if (mc_done !== 0 || stall !== 6'b0) begin
            n_fail++; $display("FAIL mc0_T+3 got stall=%b done=%b want 0 0", stall, mc_done); end
        tick();
    endtask

    task automatic test_abort;
        mc_start = 1; mc_cycles = 6'd3;
        tick();
        mc_start = 0; mc_cycles = 0;
        tick();
        mc_abort = 1; #2;
        n_chk++; if (stall !== 6'b001111 || mc_busy !== 1) begin
            n_fail++; $display("FAIL abort_T+2 got stall=%b busy=%b want 001111 1", stall, mc_busy); end
        tick();
        mc_abort = 0; #2;
        n_chk++; if (stall !== 6'b0 || mc_busy !== 0 || mc_done !== 0) begin
            n_fail++; $display("FAIL abort_T+3 got stall=%b busy=%b done=%b want 0 0 0", stall, mc_busy, mc_done); end
        for (int k = 0; k < 4; k++) begin
            tick(); #2;
            n_chk++; if (mc_done !== 0 || stall !== 6'b0) begin
                n_fail++; $display("FAIL abort_after%0d got done=%b stall=%b want 0 0", k, mc_done, stall); end
        end
        tick();
    endtask

    task automatic test_flush;
        mc_start = 1; mc_cycles = 6'd3;
        tick();
        mc_start = 0; mc_cycles = 0;
        flush_req = 1; flush_pc = 32'h0000_0040; #2;
        n_chk++; if (stall !== 6'b001111 || flush !== 0) begin
            n_fail++; $display("FAIL flush_T+1 got stall=%b flush=%b want 001111 0", stall, flush); end
        tick();
        flush_req = 0; flush_pc = 32'hDEAD_BEEF; #2;
        n_chk++; if (flush !== 1 || new_pc !== 32'h40 || stall !== 6'b0 || mc_done !== 0) begin
            n_fail++; $display("FAIL flush_T+2 got flush=%b pc=%h stall=%b done=%b want 1 00000040 0 0", flush, new_pc, stall, mc_done); end
        for (int k = 0; k < 5; k++) begin
            tick(); #2;
            n_chk++; if (mc_done !== 0 || flush !== 0 || new_pc !== 32'h40) begin
                n_fail++; $display("FAIL flush_after%0d got done=%b flush=%b pc=%h want 0 0 00000040", k, mc_done, flush, new_pc); end
        end
        tick();
    endtask

    task automatic test_back_to_back;
        // flush from IDLE with an ID request pending, then again from FLUSH
        stallreq_from_id = 1; flush_req = 1; flush_pc = 32'h0000_0080; #2;
        n_chk++; if (stall !== 6'b000111 || flush !== 0) begin
            n_fail++; $display("FAIL b2b_T got stall=%b flush=%b want 000111 0", stall, flush); end
        tick();
        flush_pc = 32'h0000_0100; #2;
        n_chk++; if (flush !== 1 || new_pc !== 32'h80 || stall !== 6'b0) begin
            n_fail++; $display("FAIL b2b_T+1 got flush=%b pc=%h stall=%b want 1 00000080 0", flush, new_pc, stall); end
        tick();
        flush_req = 0; stallreq_from_id = 0; #2;
        n_chk++; if (flush !== 1 || new_pc !== 32'h100) begin
            n_fail++; $display("FAIL b2b_T+2 got flush=%b pc=%h want 1 00000100", flush, new_pc); end
        tick(); #2;
        n_chk++; if (flush !== 0 || new_pc !== 32'h100) begin
            n_fail++; $display("FAIL b2b_T+3 got flush=%b pc=%h want 0 00000100", flush, new_pc); end
        tick();
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf;
        rst = 0; #2; tick(); rst = 1;
        stallreq_from_ex = 1;
        repeat (10) tick();
        stallreq_from_ex = 0; #2;
        n_chk++; if (stall_cycles !== 32'd10) begin
            n_fail++; $display("FAIL perf_count got %0d want 10", stall_cycles); end
        force dut.perf_q = 32'hFFFF_FFFF;
        #1; release dut.perf_q;
        stallreq_from_ex = 1;
        repeat (3) tick();
        stallreq_from_ex = 0; #2;
        n_chk++; if (stall_cycles !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL perf_saturate got %h want ffffffff", stall_cycles); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_id_ex();
        test_multicycle();
        test_abort();
        test_flush();
        test_back_to_back();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
